// File: rtl/ras_circular_stack.sv
// Circular return-address stack for the frontend predictor.
// Optional checkpoint snapshot enabled by RAS_CIRCULAR_CKPT_EN.
module ras_circular_stack #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [VLEN-1:0]            push_addr_i,
  input  logic                       pop_i,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_rest_i,
  output logic                       top_valid_o,
  output logic [VLEN-1:0]            top_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [VLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   ptr_inc, ptr_dec;

  // Explicit wrap so non-power-of-two depths stay in range
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;

`ifdef RAS_CIRCULAR_CKPT_EN
  logic [PW-1:0] snap_ptr_q;
  logic [CW-1:0] snap_cnt_q;
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save_i ^ ckpt_rest_i;
`endif

  always_comb begin
    ptr_n  = ptr_q;
    cnt_n  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush_i) begin
      cnt_n = '0;
`ifdef RAS_CIRCULAR_CKPT_EN
    end else if (ckpt_rest_i) begin
      ptr_n = snap_ptr_q;
      cnt_n = snap_cnt_q;
`endif
    end else if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0)
        cnt_n = CW'(1);
    end else if (push_i) begin
      ptr_n  = ptr_inc;
      wr_en  = 1'b1;
      wr_idx = ptr_inc;
      if (cnt_q != CW'(DEPTH))
        cnt_n = cnt_q + 1'b1;
    end else if (pop_i) begin
      if (cnt_q != '0) begin
        ptr_n = ptr_dec;
        cnt_n = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
      if (wr_en)
        mem[wr_idx] <= push_addr_i;
    end
  end

`ifdef RAS_CIRCULAR_CKPT_EN
  // Snapshot follows next-state, so save+restore keeps the restored value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_ptr_q <= '0;
      snap_cnt_q <= '0;
    end else if (ckpt_save_i) begin
      snap_ptr_q <= ptr_n;
      snap_cnt_q <= cnt_n;
    end
  end
`endif

  assign top_addr_o  = mem[ptr_q];
  assign top_valid_o = (cnt_q != '0);
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_ras_circular_stack.sv
// Scoreboard bench for ras_circular_stack at DEPTH=2.
module tb_ras_circular_stack;

  localparam int DEPTH = 2;
  localparam int VLEN  = 64;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef RAS_CIRCULAR_CKPT_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct packed {
    logic            v;
    logic [VLEN-1:0] a;
    logic [CW-1:0]   c;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            push = 1'b0;
  logic [VLEN-1:0] push_addr = '0;
  logic            pop = 1'b0;
  logic            save = 1'b0;
  logic            rest = 1'b0;
  logic            top_valid;
  logic [VLEN-1:0] top_addr;
  logic [CW-1:0]   count;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ras_circular_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_addr_i (push_addr),
    .pop_i       (pop),
    .ckpt_save_i (save),
    .ckpt_rest_i (rest),
    .top_valid_o (top_valid),
    .top_addr_o  (top_addr),
    .count_o     (count)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (top_valid !== e.v || top_addr !== e.a || count !== e.c) begin
        miscompares++;
        $display("FAIL vec%0d: got v=%0b a=%0h c=%0d, want v=%0b a=%0h c=%0d",
                 vectors, top_valid, top_addr, count, e.v, e.a, e.c);
      end
    end
  end

  task automatic step(input logic pu, input logic po, input logic fl,
                      input logic sv, input logic rs,
                      input logic [VLEN-1:0] ad,
                      input logic ev, input logic [VLEN-1:0] ea,
                      input logic [CW-1:0] ec);
    @(negedge clk);
    push = pu; pop = po; flush = fl;
    save = sv; rest = rs; push_addr = ad;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0;
    save = 0; rest = 0; push_addr = '0;
    sb.push_back({ev, ea, ec});
  endtask

  initial begin
    int budget;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back({1'b0, 64'h0, 2'd0});
    @(negedge clk);
    rst = 1'b0;
    //    pu po fl sv rs addr        v   top      cnt
    step(0, 1, 0, 0, 0, 64'h0,   0, 64'h0,   2'd0);
    step(1, 0, 0, 0, 0, 64'h100, 1, 64'h100, 2'd1);
    step(1, 0, 0, 0, 0, 64'h200, 1, 64'h200, 2'd2);
    step(0, 1, 0, 0, 0, 64'h0,   1, 64'h100, 2'd1);
    step(0, 1, 0, 0, 0, 64'h0,   0, 64'h200, 2'd0);
    step(1, 0, 0, 0, 0, 64'h100, 1, 64'h100, 2'd1);
    step(1, 0, 0, 0, 0, 64'h200, 1, 64'h200, 2'd2);
    step(1, 0, 0, 0, 0, 64'h300, 1, 64'h300, 2'd2);
    step(0, 1, 0, 0, 0, 64'h0,   1, 64'h200, 2'd1);
    step(0, 1, 0, 0, 0, 64'h0,   0, 64'h300, 2'd0);
    step(1, 0, 0, 0, 0, 64'h100, 1, 64'h100, 2'd1);
    step(1, 1, 0, 0, 0, 64'h200, 1, 64'h200, 2'd1);
    step(0, 1, 0, 0, 0, 64'h0,   0, 64'h300, 2'd0);
    step(1, 1, 0, 0, 0, 64'h40,  1, 64'h40,  2'd1);
    step(1, 0, 1, 0, 0, 64'h500, 0, 64'h40,  2'd0);
    step(1, 0, 0, 0, 0, 64'h600, 1, 64'h600, 2'd1);
    step(0, 0, 1, 0, 0, 64'h0,   0, 64'h600, 2'd0);
    step(1, 0, 0, 0, 0, 64'h100, 1, 64'h100, 2'd1);
    step(0, 0, 0, 1, 0, 64'h0,   1, 64'h100, 2'd1);
    step(1, 0, 0, 0, 0, 64'h200, 1, 64'h200, 2'd2);
    step(0, 1, 0, 0, 0, 64'h0,   1, 64'h100, 2'd1);
    step(0, 1, 0, 0, 0, 64'h0,   0, 64'h200, 2'd0);
    step(0, 0, 0, 0, 1, 64'h0,   CK, CK ? 64'h100 : 64'h200,
         CK ? 2'd1 : 2'd0);
    step(1, 0, 0, 1, 0, 64'h700, 1, 64'h700, CK ? 2'd2 : 2'd1);
    step(0, 1, 0, 0, 0, 64'h0,   CK, CK ? 64'h100 : 64'h200,
         CK ? 2'd1 : 2'd0);
    step(0, 0, 0, 1, 1, 64'h0,   CK, CK ? 64'h700 : 64'h200,
         CK ? 2'd2 : 2'd0);
    step(0, 1, 0, 0, 0, 64'h0,   CK, CK ? 64'h100 : 64'h200,
         CK ? 2'd1 : 2'd0);
    step(0, 1, 0, 0, 0, 64'h0,   0, CK ? 64'h700 : 64'h200, 2'd0);
    step(0, 0, 0, 0, 1, 64'h0,   CK, CK ? 64'h700 : 64'h200,
         CK ? 2'd2 : 2'd0);
    // asynchronous reset landing mid-request
    @(negedge clk);
    push = 1; push_addr = 64'h900;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    push = 0; push_addr = '0;
    sb.push_back({1'b0, 64'h0, 2'd0});
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 64'hA0, 1, 64'hA0, 2'd1);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
